// File: rtl/agmv_control_unit.sv
// agmv_control_unit: multicycle fetch/decode/execute sequencer for the 8-bit AGM-V core.
// Owns pc and instruction register and drives memory strobes, register-file addresses and ALU op.
module agmv_control_unit #(
   parameter logic [7:0] PC_RESET   = 8'h00,
   parameter int         WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ready,
   input  logic       alu_zero,
   output logic [7:0] pc,
   output logic [7:0] mem_addr,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic [7:0] ADR_1,
   output logic [7:0] ADR_2,
   output logic [7:0] ADR_3,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic [2:0] alu_op,
   output logic [7:0] imm,
   output logic       halted,
   output logic       bus_err,
   output logic       illegal_op
);
   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   typedef enum logic [2:0] {FETCH0, FETCH1, DECODE, EXEC, MEM, HALT} state_t;
   state_t state, state_nxt;
   logic [7:0] ir;
   logic [CW-1:0] wait_cnt;
   logic [3:0] op;
   logic [1:0] rd, rs;
   logic is_alu, is_ld, is_st, taken, access, overrun;
   assign op = ir[7:4];
   assign rd = ir[3:2];
   assign rs = ir[1:0];
   assign is_alu = op inside {[4'h1:4'h4]};
   assign is_ld = op == 4'h6;
   assign is_st = op == 4'h7;
   assign taken = op == 4'h8 || (op == 4'h9 && alu_zero);
   assign access = state == FETCH0 || state == FETCH1 || state == MEM;
   // a limit of zero disables the timeout; the counter then simply sits at zero
   assign overrun = WAIT_LIMIT != 0 && access && !mem_ready && wait_cnt == CW'(WAIT_LIMIT);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FETCH0;
         pc       <= PC_RESET;
         ir       <= '0;
         imm      <= '0;
         wait_cnt <= '0;
         bus_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= (state_nxt != state || mem_ready || !access) ? '0 :
                     wait_cnt + CW'(wait_cnt != CW'(WAIT_LIMIT));
         if (overrun) bus_err <= 1'b1;
         if (state == FETCH0 && mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 8'd1;
         end
         if (state == FETCH1 && mem_ready) begin
            imm <= mem_rdata;
            pc  <= pc + 8'd1;
         end
         if (state == EXEC && taken) pc <= imm;
      end
   end
   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH0:  state_nxt = mem_ready ? FETCH1 : FETCH0;
         FETCH1:  state_nxt = mem_ready ? DECODE : FETCH1;
         DECODE:  state_nxt = EXEC;
         EXEC:    state_nxt = (is_ld || is_st) ? MEM : (op == 4'hF) ? HALT : FETCH0;
         MEM:     state_nxt = mem_ready ? FETCH0 : MEM;
         default: state_nxt = HALT;
      endcase
      if (overrun) state_nxt = HALT;
   end
   // strobes are gated by rst so they drop the instant reset is asserted
   always_comb begin
      mem_addr   = (state == MEM) ? imm : pc;
      mem_rd     = rst && (state == FETCH0 || state == FETCH1 || (state == MEM && is_ld));
      mem_wr     = rst && state == MEM && is_st;
      reg_we     = rst && ((state == EXEC && (is_alu || op == 4'h5)) || (state == MEM && is_ld && mem_ready));
      wb_sel     = (op == 4'h5) ? 2'd1 : is_ld ? 2'd2 : 2'd0;
      alu_op     = is_alu ? {1'b0, op[1:0] - 2'd1} : 3'd1;
      halted     = state == HALT;
      illegal_op = rst && state == EXEC && op inside {[4'hA:4'hE]};
   end
   assign ADR_1 = {6'b0, rd};
   assign ADR_2 = {6'b0, rs};
   assign ADR_3 = {6'b0, rd};
endmodule

// File: tb/tb_agmv_control_unit.sv
// tb_agmv_control_unit: drives the sequencer with a memory/register-file/ALU harness and
// checks it cycle by cycle against an instruction-level model of the AGM-V ISA.
module tb_agmv_control_unit;
   logic clk = 1'b0, rst = 1'b0, mem_ready = 1'b0, alu_zero;
   logic [7:0] mem_rdata, pc, mem_addr, ADR_1, ADR_2, ADR_3, imm;
   logic mem_rd, mem_wr, reg_we, halted, bus_err, illegal_op;
   logic [1:0] wb_sel;
   logic [2:0] alu_op;
   logic [7:0] mem [256];
   logic [7:0] rf [4];
   logic [7:0] m_mem [256];
   logic [7:0] m_rf [4];
   logic [7:0] m_pc;
   logic [7:0] alu_a, alu_b, alu_res;
   int n_cmp = 0, n_bad = 0;

   agmv_control_unit dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_zero(alu_zero),
      .pc(pc), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .ADR_1(ADR_1), .ADR_2(ADR_2), .ADR_3(ADR_3), .reg_we(reg_we), .wb_sel(wb_sel),
      .alu_op(alu_op), .imm(imm), .halted(halted), .bus_err(bus_err), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];
   always_comb begin
      alu_a = rf[ADR_1[1:0]];
      alu_b = rf[ADR_2[1:0]];
      alu_res = (alu_op == 3'd0) ? alu_a + alu_b : (alu_op == 3'd1) ? alu_a - alu_b :
                (alu_op == 3'd2) ? (alu_a & alu_b) : (alu_a | alu_b);
   end
   assign alu_zero = alu_res == 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock cycle; e_st = {mem_rd, mem_wr, reg_we, illegal_op, halted}
   task automatic step(input logic rdy, input logic [4:0] e_st, input logic [7:0] e_addr,
                       input logic ca, input string tag);
      logic we, mw;
      logic [1:0] wi;
      logic [7:0] wv, ma, mv;
      mem_ready = rdy;
      #1;
      chk({tag, " strobes"}, {mem_rd, mem_wr, reg_we, illegal_op, halted}, e_st);
      if (ca) chk({tag, " addr"}, mem_addr, e_addr);
      we = reg_we;
      wi = ADR_3[1:0];
      wv = (wb_sel == 2'd0) ? alu_res : (wb_sel == 2'd1) ? imm : mem_rdata;
      mw = mem_wr && mem_ready;
      ma = mem_addr;
      mv = rf[ADR_1[1:0]];
      @(posedge clk);
      if (we) rf[wi] = wv;
      if (mw) mem[ma] = mv;
      #1;
   endtask

   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("reset flags", {mem_rd, mem_wr, reg_we, illegal_op, halted, bus_err}, 0);
      chk("reset pc", pc, 8'h00);
      chk("reset adr/imm", {ADR_1, ADR_2, ADR_3, imm}, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      m_pc = 8'h00;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0] a1;
      a1 = a + 8'd1;
      mem[a] = b0;
      mem[a1] = b1;
      m_mem[a] = b0;
      m_mem[a1] = b1;
   endtask

   // executes one instruction: ISA-level model update plus expected bus activity per cycle
   task automatic run_instr(input int w0, input int w1, input int wm);
      logic [7:0] p, p1, b0, b1;
      logic [3:0] op;
      logic [1:0] rd, rs;
      logic ld, st, we, ill, br;
      p = m_pc;
      p1 = p + 8'd1;
      b0 = m_mem[p];
      b1 = m_mem[p1];
      op = b0[7:4];
      rd = b0[3:2];
      rs = b0[1:0];
      ld = op == 4'h6;
      st = op == 4'h7;
      we = op >= 4'h1 && op <= 4'h5;
      ill = op >= 4'hA && op <= 4'hE;
      for (int i = 0; i < w0; i++) step(1'b0, 5'b10000, p, 1'b1, "fetch0");
      step(1'b1, 5'b10000, p, 1'b1, "fetch0");
      for (int i = 0; i < w1; i++) step(1'b0, 5'b10000, p1, 1'b1, "fetch1");
      step(1'b1, 5'b10000, p1, 1'b1, "fetch1");
      chk("decode adr/imm", {ADR_1, ADR_2, ADR_3, imm}, {6'b0, rd, 6'b0, rs, 6'b0, rd, b1});
      if ((op >= 4'h1 && op <= 4'h4) || op == 4'h9)
         chk("alu_op", alu_op, (op == 4'h9) ? 3'd1 : 3'(op - 4'h1));
      step(1'($urandom_range(0, 1)), 5'b00000, 8'h00, 1'b0, "decode");
      if (we) chk("wb_sel exec", wb_sel, (op == 4'h5) ? 2'd1 : 2'd0);
      step(1'($urandom_range(0, 1)), {2'b00, we, ill, 1'b0}, 8'h00, 1'b0, "exec");
      if (ld || st) begin
         if (ld) chk("wb_sel mem", wb_sel, 2'd2);
         for (int i = 0; i < wm; i++) step(1'b0, {ld, st, 3'b000}, b1, 1'b1, "mem wait");
         step(1'b1, {ld, st, ld, 2'b00}, b1, 1'b1, "mem");
      end
      if (op == 4'hF)
         for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 5'b00001, 8'h00, 1'b0, "halt");
      br = op == 4'h8 || (op == 4'h9 && m_rf[rd] == m_rf[rs]);
      case (op)
         4'h1: m_rf[rd] = m_rf[rd] + m_rf[rs];
         4'h2: m_rf[rd] = m_rf[rd] - m_rf[rs];
         4'h3: m_rf[rd] = m_rf[rd] & m_rf[rs];
         4'h4: m_rf[rd] = m_rf[rd] | m_rf[rs];
         4'h5: m_rf[rd] = b1;
         4'h6: m_rf[rd] = m_mem[b1];
         4'h7: m_mem[b1] = m_rf[rd];
         default: ;
      endcase
      m_pc = br ? b1 : p + 8'd2;
      chk("pc", pc, m_pc);
      chk("regfile", {rf[0], rf[1], rf[2], rf[3]}, {m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
      if (st) chk("store data", mem[b1], m_mem[b1]);
   endtask

   initial begin
      bit hs;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         m_mem[i] = 8'h00;
      end
      for (int i = 0; i < 4; i++) begin
         rf[i] = 8'h00;
         m_rf[i] = 8'h00;
      end
      #1 do_reset();
      // LDI r1,5; LDI r2,5; ADD r1,r2; ST r1,[40]; LD r3,[40]; BEQ/LDI/BEQ; illegal; JMP FE; LDI at FE
      load(8'h00, 8'h54, 8'h05);
      load(8'h02, 8'h58, 8'h05);
      load(8'h04, 8'h16, 8'h00);
      load(8'h06, 8'h74, 8'h40);
      load(8'h08, 8'h6C, 8'h40);
      load(8'h0A, 8'h96, 8'h20);
      load(8'h0C, 8'h58, 8'h0A);
      load(8'h0E, 8'h96, 8'h20);
      load(8'h20, 8'hB0, 8'h00);
      load(8'h22, 8'h80, 8'hFE);
      load(8'hFE, 8'h50, 8'h07);
      repeat (3) run_instr(0, 0, 0);
      chk("add result r1", rf[1], 8'd10);
      repeat (2) run_instr(0, 0, 2);
      chk("ld result r3", rf[3], 8'd10);
      repeat (6) run_instr(0, 0, 0);
      chk("wrap pc", pc, 8'h00);
      step(1'b0, 5'b10000, 8'h00, 1'b1, "pre-reset");
      step(1'b0, 5'b10000, 8'h00, 1'b1, "pre-reset");
      do_reset();
      load(8'h00, 8'hF0, 8'h00);
      run_instr(1, 0, 0);
      do_reset();
      for (int i = 0; i < 15; i++) step(1'b0, 5'b10000, 8'h00, 1'b1, "long wait");
      mem_ready = 1'b0;
      @(posedge clk);
      #1 chk("bus error", {bus_err, halted, mem_rd, mem_wr, reg_we}, 5'b11000);
      step(1'b1, 5'b00001, 8'h00, 1'b0, "after bus error");
      chk("bus_err sticky", bus_err, 1'b1);
      do_reset();
      load(8'h00, 8'h00, 8'h00);
      run_instr(15, 15, 0);
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h0;
         m_mem[i] = mem[i];
      end
      for (int i = 0; i < 4; i++) begin
         rf[i] = 8'($urandom_range(0, 3));
         m_rf[i] = rf[i];
      end
      do_reset();
      for (int n = 0; n < 300; n++) begin
         hs = m_mem[m_pc][7:4] == 4'hF;
         run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                   $urandom_range(0, 3));
         if (hs) break;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
